// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host controller: register map, LSR bit
// positions and the controller state encoding.
package uart_host_pkg;

    localparam logic [2:0] ADDR_RBR_THR_DLL = 3'd0;
    localparam logic [2:0] ADDR_DLM         = 3'd1;
    localparam logic [2:0] ADDR_FCR         = 3'd2;
    localparam logic [2:0] ADDR_LCR         = 3'd3;
    localparam logic [2:0] ADDR_LSR         = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_PE   = 2;
    localparam int LSR_FE   = 3;
    localparam int LSR_BI   = 4;
    localparam int LSR_THRE = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_DLAB,
        S_W_DLL,
        S_W_DLM,
        S_W_LCR,
        S_W_FCR,
        S_RD_LSR,
        S_WAIT_LSR,
        S_RD_RBR,
        S_WAIT_RBR,
        S_W_THR,
        S_POLL_GAP
    } host_state_t;

endpackage

// File: rtl/uart_host_ctrl.sv
// Register-port initiator for a 16550-style UART: programs the line setup,
// then polls LSR and shuttles bytes between the stream ports and THR/RBR.
module uart_host_ctrl
    import uart_host_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_fcr,
    output logic        cfg_done,
    output logic        busy,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [3:0]  err_flags,
    output logic        wr,
    output logic        rd,
    output logic [2:0]  addr,
    output logic [7:0]  din,
    input  logic [7:0]  dout
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;

    host_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             restart_pend;
    logic [2:0]       addr_nxt;
    logic [7:0]       din_nxt;
    logic             in_run, cfg_req, restart, cnt_zero, lsr_sampled, rbr_sampled;

    assign in_run = (state == S_RD_LSR) || (state == S_WAIT_LSR) || (state == S_RD_RBR) ||
                    (state == S_WAIT_RBR) || (state == S_W_THR) || (state == S_POLL_GAP);
    assign cfg_req     = cfg_start && ((state == S_IDLE) || in_run);
    assign restart     = restart_pend || cfg_start;
    assign cnt_zero    = (cnt == '0);
    assign lsr_sampled = (state == S_WAIT_LSR) && cnt_zero;
    assign rbr_sampled = (state == S_WAIT_RBR) && cnt_zero;

    assign wr = (state == S_W_DLAB) || (state == S_W_DLL) || (state == S_W_DLM) ||
                (state == S_W_LCR) || (state == S_W_FCR) || (state == S_W_THR);
    assign rd       = (state == S_RD_LSR) || (state == S_RD_RBR);
    assign tx_ready = (state == S_W_THR);
    assign busy     = !((state == S_IDLE) || (state == S_POLL_GAP));

    // A reconfigure request arriving with a read in flight lets that read finish
    // and throws its data away before the write sequence restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE:   if (cfg_start) state_nxt = S_W_DLAB;
            S_W_DLAB: state_nxt = S_W_DLL;
            S_W_DLL:  state_nxt = S_W_DLM;
            S_W_DLM:  state_nxt = S_W_LCR;
            S_W_LCR:  state_nxt = S_W_FCR;
            S_W_FCR:  state_nxt = S_RD_LSR;
            S_RD_LSR: begin
                state_nxt = S_WAIT_LSR;
                cnt_nxt   = LAT_LOAD;
            end
            S_WAIT_LSR: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (restart) begin
                    state_nxt = S_W_DLAB;
                end else if (dout[LSR_DR] && !rx_valid) begin
                    state_nxt = S_RD_RBR;
                end else if (dout[LSR_THRE] && tx_valid) begin
                    state_nxt = S_W_THR;
                end else if (POLL_GAP == 0) begin
                    state_nxt = S_RD_LSR;
                end else begin
                    state_nxt = S_POLL_GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            S_RD_RBR: begin
                state_nxt = S_WAIT_RBR;
                cnt_nxt   = LAT_LOAD;
            end
            S_WAIT_RBR: begin
                if (!cnt_zero) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = restart ? S_W_DLAB : S_RD_LSR;
            end
            S_W_THR:  state_nxt = cfg_start ? S_W_DLAB : S_RD_LSR;
            S_POLL_GAP: begin
                if (cfg_start)     state_nxt = S_W_DLAB;
                else if (cnt_zero) state_nxt = S_RD_LSR;
                else               cnt_nxt = cnt - CNT_W'(1);
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        addr_nxt = addr;
        din_nxt  = din;
        case (state_nxt)
            S_W_DLAB: begin addr_nxt = ADDR_LCR;         din_nxt = 8'h80;           end
            S_W_DLL:  begin addr_nxt = ADDR_RBR_THR_DLL; din_nxt = cfg_div[7:0];    end
            S_W_DLM:  begin addr_nxt = ADDR_DLM;         din_nxt = cfg_div[15:8];   end
            S_W_LCR:  begin addr_nxt = ADDR_LCR;         din_nxt = cfg_lcr & 8'h7F; end
            S_W_FCR:  begin addr_nxt = ADDR_FCR;         din_nxt = cfg_fcr;         end
            S_W_THR:  begin addr_nxt = ADDR_RBR_THR_DLL; din_nxt = tx_data;         end
            S_RD_LSR: addr_nxt = ADDR_LSR;
            S_RD_RBR: addr_nxt = ADDR_RBR_THR_DLL;
            default:  ;
        endcase
    end

    // Error bits accumulate over every kept LSR sample until the next reconfigure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            restart_pend <= 1'b0;
            addr         <= '0;
            din          <= '0;
            cfg_done     <= 1'b0;
            err_flags    <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            restart_pend <= ((state_nxt == S_WAIT_LSR) || (state_nxt == S_WAIT_RBR)) &&
                            (restart_pend || cfg_req);
            addr         <= addr_nxt;
            din          <= din_nxt;

            if (cfg_req)                 cfg_done <= 1'b0;
            else if (state == S_W_FCR)   cfg_done <= 1'b1;

            if (cfg_req)
                err_flags <= '0;
            else if (lsr_sampled && !restart)
                err_flags <= err_flags | {dout[LSR_BI], dout[LSR_FE], dout[LSR_PE], dout[LSR_OE]};

            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (rbr_sampled && !restart) begin
                rx_valid <= 1'b1;
                rx_data  <= dout;
            end
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: a small UART register model answers
// reads, a monitor checks every bus write and RX handshake against queues.
module tb_uart_host_ctrl;

    localparam int RD_LAT   = 2;
    localparam int POLL_GAP = 3;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] din;
        logic       txr;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, cfg_start;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_lcr, cfg_fcr;
    logic        cfg_done, busy;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic [3:0]  err_flags;
    logic        wr, rd;
    logic [2:0]  addr;
    logic [7:0]  din, dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lsr_reads = 0;
    int rbr_reads = 0;
    int last_rbr_cyc = 0;
    int n, snap, mark;

    wr_t        exp_wr[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_fifo[$];
    logic [7:0] lsr_base;
    logic       pipe_vld [RD_LAT];
    logic [7:0] pipe_dat [RD_LAT];

    always #5 clk = ~clk;

    uart_host_ctrl #(.RD_LAT(RD_LAT), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_div(cfg_div),
        .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr), .cfg_done(cfg_done), .busy(busy),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .err_flags(err_flags), .wr(wr), .rd(rd), .addr(addr), .din(din), .dout(dout)
    );

    // UART register model: value is fixed when rd is seen, presented RD_LAT cycles later.
    always @(posedge clk) begin
        logic [7:0] v;
        v = 8'h00;
        if (rd && addr == 3'd5)
            v = {lsr_base[7:1], rx_fifo.size() != 0};
        else if (rd && addr == 3'd0 && rx_fifo.size() != 0)
            v = rx_fifo.pop_front();
        pipe_vld[0] <= rd;
        pipe_dat[0] <= v;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
        end
        cyc <= cyc + 1;
    end

    assign dout = pipe_vld[RD_LAT-1] ? pipe_dat[RD_LAT-1] : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every write and every RX handshake is matched against the queues.
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] r;
        if (wr === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%0d din=%h expected none", addr, din);
            end else begin
                e = exp_wr.pop_front();
                checkOutput("bus_write", {addr, din, tx_ready}, e);
            end
        end
        if (rd === 1'b1 && addr == 3'd0) begin
            rbr_reads++;
            last_rbr_cyc = cyc;
        end
        if (rd === 1'b1 && addr == 3'd5) lsr_reads++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_rx.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rx: got %h expected none", rx_data);
            end else begin
                r = exp_rx.pop_front();
                checkOutput("rx_byte", rx_data, r);
            end
        end
    end

    task automatic applyStimulus(input logic tv, input logic [7:0] td, input logic rr,
                                 input logic [7:0] lb);
        @(posedge clk);
        #1;
        tx_valid = tv;
        tx_data  = td;
        rx_ready = rr;
        lsr_base = lb;
    endtask

    task automatic pulseCfg();
        @(posedge clk);
        #1 cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic pushCfg(input logic [7:0] dll, input logic [7:0] dlm,
                           input logic [7:0] lcr, input logic [7:0] fcr);
        exp_wr.push_back(wr_t'({3'd3, 8'h80, 1'b0}));
        exp_wr.push_back(wr_t'({3'd0, dll, 1'b0}));
        exp_wr.push_back(wr_t'({3'd1, dlm, 1'b0}));
        exp_wr.push_back(wr_t'({3'd3, lcr, 1'b0}));
        exp_wr.push_back(wr_t'({3'd2, fcr, 1'b0}));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0;
        cfg_div = 16'h0108; cfg_lcr = 8'h8C; cfg_fcr = 8'h01;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; lsr_base = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_bus", {wr, rd, addr, din}, 0);
        checkOutput("rst_stream", {tx_ready, rx_valid, rx_data}, 0);
        checkOutput("rst_status", {cfg_done, busy, err_flags}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_quiet", {busy, wr, rd}, 0);

        // Initial configuration: five back-to-back writes, then cfg_done.
        pushCfg(8'h08, 8'h01, 8'h0C, 8'h01);
        pulseCfg();
        n = 0;
        do begin @(negedge clk); n++; end while (wr !== 1'b1 && n < 20);
        checkOutput("cfg_wr0", wr, 1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checkOutput("cfg_wr_consecutive", wr, 1);
        end
        checkOutput("cfg_done_during_fcr", cfg_done, 0);
        @(negedge clk);
        checkOutput("cfg_done_after", {cfg_done, busy, rd}, 3'b111);

        // TX: two bytes, exactly one LSR poll between THR writes.
        exp_wr.push_back(wr_t'({3'd0, 8'hF0, 1'b1}));
        exp_wr.push_back(wr_t'({3'd0, 8'hF1, 1'b1}));
        applyStimulus(1'b1, 8'hF0, 1'b0, 8'h60);
        n = 0;
        do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 100);
        checkOutput("tx_first", tx_ready, 1);
        applyStimulus(1'b1, 8'hF1, 1'b0, 8'h60);
        snap = lsr_reads;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 100);
        checkOutput("tx_second", tx_ready, 1);
        checkOutput("one_poll_per_thr", lsr_reads - snap, 1);
        applyStimulus(1'b0, 8'hF1, 1'b0, 8'h60);

        // RX with backpressure: second byte must wait for the first to drain.
        snap = rbr_reads;
        rx_fifo.push_back(8'h5A); rx_fifo.push_back(8'h77);
        exp_rx.push_back(8'h5A);  exp_rx.push_back(8'h77);
        n = 0;
        do begin @(negedge clk); n++; end while (rx_valid !== 1'b1 && n < 100);
        checkOutput("rx_captured", {rx_valid, rx_data}, {1'b1, 8'h5A});
        repeat (30) @(negedge clk);
        checkOutput("rx_held", {rx_valid, rx_data}, {1'b1, 8'h5A});
        checkOutput("no_rbr_while_full", rbr_reads - snap, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h60);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rx_cleared", rx_valid, 0);
        repeat (40) @(negedge clk);
        checkOutput("rx_second_read", rbr_reads - snap, 2);
        checkOutput("rx_all_delivered", exp_rx.size(), 0);

        // Priority: with DR and THRE both set the RBR read goes first.
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 50);
        checkOutput("gap_reached", busy, 0);
        mark = cyc;
        rx_fifo.push_back(8'hA5);
        exp_rx.push_back(8'hA5);
        exp_wr.push_back(wr_t'({3'd0, 8'h3C, 1'b1}));
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_ready !== 1'b1 && n < 100);
        checkOutput("prio_tx_done", tx_ready, 1);
        checkOutput("prio_rx_first", (last_rbr_cyc > mark) && (last_rbr_cyc < cyc), 1);
        applyStimulus(1'b0, 8'h3C, 1'b1, 8'h60);
        repeat (10) @(negedge clk);
        checkOutput("prio_rx_delivered", exp_rx.size(), 0);

        // Error flags: LSR=0x0D once gives {BI,FE,PE,OE}=0110, sticky.
        rx_fifo.push_back(8'h33);
        exp_rx.push_back(8'h33);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h0C);
        n = 0;
        do begin @(negedge clk); n++; end while (err_flags == 4'd0 && n < 100);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h60);
        checkOutput("err_flags", err_flags, 4'b0110);
        repeat (20) @(negedge clk);
        checkOutput("err_sticky", err_flags, 4'b0110);

        // Reconfigure during an RBR read: byte discarded, errors cleared.
        cfg_div = 16'h1234; cfg_lcr = 8'hFF; cfg_fcr = 8'hC7;
        rx_fifo.push_back(8'h99);
        n = 0;
        do begin @(negedge clk); n++; end while (!(rd === 1'b1 && addr == 3'd0) && n < 100);
        checkOutput("rbr_read_issued", {rd, addr}, {1'b1, 3'd0});
        pushCfg(8'h34, 8'h12, 8'h7F, 8'hC7);
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
        @(negedge clk);
        checkOutput("reconfig_clears", {cfg_done, err_flags}, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (cfg_done !== 1'b1 && n < 50);
        checkOutput("reconfig_done", cfg_done, 1);
        checkOutput("discard_no_rx", rx_valid, 0);
        checkOutput("reconfig_writes", exp_wr.size(), 0);

        // Reset while the DLM write is on the bus: nothing further is written.
        exp_wr.push_back(wr_t'({3'd3, 8'h80, 1'b0}));
        exp_wr.push_back(wr_t'({3'd0, 8'h34, 1'b0}));
        exp_wr.push_back(wr_t'({3'd1, 8'h12, 1'b0}));
        pulseCfg();
        n = 0;
        do begin @(negedge clk); n++; end while (!(wr === 1'b1 && addr == 3'd1) && n < 50);
        checkOutput("dlm_write_seen", {wr, addr}, {1'b1, 3'd1});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_bus", {wr, rd, addr, din}, 0);
        checkOutput("rst_mid_status", {cfg_done, busy, err_flags, rx_valid, tx_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rst_no_more_writes", exp_wr.size(), 0);
        checkOutput("rst_idle", {busy, cfg_done}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
